// File: rtl/dct_block_former_if.sv
// Raster-in / block-out signal bundle for dct_block_former.
// The slave side is the block former; the master side is the video source / block sink.
interface dct_block_former_if;
  logic       vs_in;
  logic       de_in;
  logic [7:0] data_in_01, data_in_02, data_in_03, data_in_04;
  logic [7:0] data_in_05, data_in_06, data_in_07, data_in_08;

  logic       de_out;
  logic [7:0] data_out_01, data_out_02, data_out_03, data_out_04;
  logic [7:0] data_out_05, data_out_06, data_out_07, data_out_08;
  logic [2:0] row_out;
  logic       sob_out;
  logic       sof_out;
  logic       err_len;
  logic       err_ovf;

  modport master (
    output vs_in, de_in,
    output data_in_01, data_in_02, data_in_03, data_in_04,
    output data_in_05, data_in_06, data_in_07, data_in_08,
    input  de_out, row_out, sob_out, sof_out, err_len, err_ovf,
    input  data_out_01, data_out_02, data_out_03, data_out_04,
    input  data_out_05, data_out_06, data_out_07, data_out_08
  );

  modport slave (
    input  vs_in, de_in,
    input  data_in_01, data_in_02, data_in_03, data_in_04,
    input  data_in_05, data_in_06, data_in_07, data_in_08,
    output de_out, row_out, sob_out, sof_out, err_len, err_ovf,
    output data_out_01, data_out_02, data_out_03, data_out_04,
    output data_out_05, data_out_06, data_out_07, data_out_08
  );
endinterface

// File: rtl/dct_block_former.sv
// Raster-to-8x8-block reorder for one colour channel: 8 lines land in one bank of a
// ping-pong line store while the other bank is read out block by block, row by row.
module dct_block_former #(
  parameter int H_WORDS = 240,
  parameter int AW      = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  dct_block_former_if.slave vid
);
  // Address is {bank, line, word}, so the store spans the full AW-bit word field.
  localparam int DEPTH  = 16 << AW;
  localparam int STAGES = 1;

  localparam logic [AW:0]   HW       = (AW+1)'(H_WORDS);
  localparam logic [AW:0]   HW_SAT   = (AW+1)'(H_WORDS + 1);
  localparam logic [AW:0]   WORD_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] BLK_LAST = AW'(H_WORDS - 1);
  localparam logic [AW-1:0] BLK_ONE  = AW'(1);

  typedef enum logic {IDLE, READ} rd_state_t;

  // ---------------- write side ----------------
  logic            vs_d, de_d;
  logic            vs_rise, de_fall, band_done;
  logic            wbank;
  logic [2:0]      line_cnt;
  logic [AW:0]     word_cnt;
  logic [2:0]      wr_line;
  logic [AW:0]     wr_word;
  logic            wr_en;
  logic [AW+3:0]   wr_addr;
  logic [7:0][7:0] win;
  logic            err_len_q;

  assign win = {vid.data_in_08, vid.data_in_07, vid.data_in_06, vid.data_in_05,
                vid.data_in_04, vid.data_in_03, vid.data_in_02, vid.data_in_01};

  always_comb begin
    vs_rise   = vid.vs_in & ~vs_d;
    de_fall   = de_d & ~vid.de_in;
    band_done = de_fall & ~vs_rise & (line_cnt == 3'd7);
    // A word arriving with the vs edge belongs to the new frame's line 0, word 0.
    wr_line   = vs_rise ? 3'd0 : line_cnt;
    wr_word   = vs_rise ? '0 : word_cnt;
    wr_en     = vid.de_in & (wr_word < HW);
    wr_addr   = {wbank, wr_line, wr_word[AW-1:0]};
  end

  // word_cnt saturates one past H_WORDS so long lines stay distinguishable from exact ones.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      wbank     <= 1'b0;
      line_cnt  <= 3'd0;
      word_cnt  <= '0;
      err_len_q <= 1'b0;
    end else begin
      vs_d <= vid.vs_in;
      de_d <= vid.de_in;
      if (vs_rise) begin
        line_cnt  <= 3'd0;
        word_cnt  <= vid.de_in ? WORD_ONE : '0;
        err_len_q <= 1'b0;
      end else if (de_fall) begin
        if (word_cnt != HW) err_len_q <= 1'b1;
        word_cnt <= '0;
        line_cnt <= line_cnt + 3'd1;
        if (line_cnt == 3'd7) wbank <= ~wbank;
      end else if (vid.de_in && word_cnt != HW_SAT) begin
        word_cnt <= word_cnt + WORD_ONE;
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_t     st, st_nxt;
  logic          accept;
  logic          rbank;
  logic [2:0]    row;
  logic [AW-1:0] blk;
  logic          sof_arm, sof_pend;
  logic          err_ovf_q;
  logic [STAGES:0] vld_pipe;
  logic [AW+3:0] rd_addr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    accept = 1'b0;
    case (st)
      IDLE: if (band_done) begin
        st_nxt = READ;
        accept = 1'b1;
      end
      READ: if (row == 3'd7 && blk == BLK_LAST) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  assign rd_addr = {rbank, row, blk};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rbank     <= 1'b0;
      row       <= 3'd0;
      blk       <= '0;
      sof_arm   <= 1'b0;
      sof_pend  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (vs_rise) begin
        sof_arm   <= 1'b1;
        err_ovf_q <= 1'b0;
      end
      // A band finishing while the reader is busy is dropped, not queued.
      if (band_done && st == READ) err_ovf_q <= 1'b1;
      if (accept) begin
        rbank    <= wbank;
        row      <= 3'd0;
        blk      <= '0;
        sof_pend <= sof_arm;
        sof_arm  <= 1'b0;
      end else if (vld_pipe[0]) begin
        row      <= row + 3'd1;
        if (row == 3'd7) blk <= blk + BLK_ONE;
        sof_pend <= 1'b0;
      end
    end
  end

  // vld_pipe[0]: read issued this cycle; vld_pipe[STAGES]: RAM data valid.
  logic [2:0] row_q;
  logic       sob_q, sof_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_pipe <= '0;
      row_q    <= 3'd0;
      sob_q    <= 1'b0;
      sof_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], st_nxt == READ};
      row_q    <= vld_pipe[0] ? row : 3'd0;
      sob_q    <= vld_pipe[0] && row == 3'd0;
      sof_q    <= vld_pipe[0] && row == 3'd0 && blk == '0 && sof_pend;
    end
  end

  // ---------------- line store ----------------
  logic [63:0] mem [DEPTH];
  logic [63:0] rdata;

  always_ff @(posedge clk) begin
    if (wr_en)       mem[wr_addr] <= win;
    if (vld_pipe[0]) rdata        <= mem[rd_addr];
  end

  // Data is gated so the outputs read 0 whenever no row-word is being presented.
  logic [7:0][7:0] dout;
  assign dout = vld_pipe[STAGES] ? rdata : '0;

  assign vid.de_out      = vld_pipe[STAGES];
  assign vid.row_out     = row_q;
  assign vid.sob_out     = sob_q;
  assign vid.sof_out     = sof_q;
  assign vid.err_len     = err_len_q;
  assign vid.err_ovf     = err_ovf_q;
  assign vid.data_out_01 = dout[0];
  assign vid.data_out_02 = dout[1];
  assign vid.data_out_03 = dout[2];
  assign vid.data_out_04 = dout[3];
  assign vid.data_out_05 = dout[4];
  assign vid.data_out_06 = dout[5];
  assign vid.data_out_07 = dout[6];
  assign vid.data_out_08 = dout[7];
endmodule

// File: tb/tb_dct_block_former.sv
// Scoreboarded bench for dct_block_former with a 4-word line (H_WORDS=4).
// Driver feeds random raster lines and queues expected row-words; a monitor pops and compares.
module tb_dct_block_former;
  localparam int H  = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  dct_block_former_if vid();
  dct_block_former #(.H_WORDS(H), .AW(AW)) dut (.clk(clk), .rst_b(rst_b), .vid(vid));

  typedef struct {
    logic [63:0] data;
    logic [2:0]  row;
    logic        sob;
    logic        sof;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: line store contents per bank/line/word plus frame bookkeeping.
  logic [63:0] ram [2][8][H];
  int wbank_m = 0, line_m = 0, busy_until = -1;
  bit sof_arm_m = 0, exp_len = 0, exp_ovf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_err_len"}, vid.err_len, exp_len);
    chk({tag, "_err_ovf"}, vid.err_ovf, exp_ovf);
  endtask

  task automatic vs_model();
    line_m    = 0;
    sof_arm_m = 1;
    exp_len   = 0;
    exp_ovf   = 0;
  endtask

  // Called in the first cycle with de_in low after a line.
  task automatic end_line(input int n);
    if (n != H) exp_len = 1;
    line_m++;
    if (line_m == 8) begin
      line_m = 0;
      if (cyc <= busy_until) exp_ovf = 1;
      else begin
        for (int b = 0; b < H; b++)
          for (int r = 0; r < 8; r++) begin
            exp_t e;
            e.data = ram[wbank_m][r][b];
            e.row  = 3'(r);
            e.sob  = (r == 0);
            e.sof  = sof_arm_m && b == 0 && r == 0;
            e.cyc  = cyc + 2 + b * 8 + r;
            sb.push_back(e);
          end
        sof_arm_m  = 0;
        busy_until = cyc + 8 * H;
      end
      wbank_m ^= 1;
    end
  endtask

  task automatic send_line(input int n, input int blank, input bit with_vs);
    logic [63:0] w;
    if (with_vs) begin
      vs_model();
      vid.vs_in = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      vid.de_in = 1'b1;
      {vid.data_in_08, vid.data_in_07, vid.data_in_06, vid.data_in_05,
       vid.data_in_04, vid.data_in_03, vid.data_in_02, vid.data_in_01} = w;
      if (i < H) ram[wbank_m][line_m][i] = w;
      tick();
      vid.vs_in = 1'b0;
    end
    vid.de_in = 1'b0;
    end_line(n);
    repeat (blank) tick();
  endtask

  task automatic send_band(input int n, input int blank);
    for (int l = 0; l < 8; l++) send_line(n, blank, 1'b0);
  endtask

  task automatic vsync(input string tag);
    vid.vs_in = 1'b1;
    vs_model();
    tick();
    vid.vs_in = 1'b0;
    check_flags(tag);
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() > 0; i++) tick();
    chk({tag, "_drain_left"}, sb.size(), 0);
  endtask

  // Monitor
  exp_t        m_e;
  logic [63:0] m_act;
  always @(negedge clk) begin
    if (vid.de_out === 1'b1) begin
      checks++;
      m_act = {vid.data_out_08, vid.data_out_07, vid.data_out_06, vid.data_out_05,
               vid.data_out_04, vid.data_out_03, vid.data_out_02, vid.data_out_01};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_de_out: cycle %0d data %0h, no row-word expected", cyc, m_act);
      end else begin
        m_e = sb.pop_front();
        if (m_act !== m_e.data || vid.row_out !== m_e.row || vid.sob_out !== m_e.sob ||
            vid.sof_out !== m_e.sof || cyc != m_e.cyc) begin
          errors++;
          $display("FAIL row_word: got data=%0h row=%0d sob=%0b sof=%0b cyc=%0d want data=%0h row=%0d sob=%0b sof=%0b cyc=%0d",
                   m_act, vid.row_out, vid.sob_out, vid.sof_out, cyc,
                   m_e.data, m_e.row, m_e.sob, m_e.sof, m_e.cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vid.vs_in = 1'b0;
    vid.de_in = 1'b0;
    {vid.data_in_08, vid.data_in_07, vid.data_in_06, vid.data_in_05,
     vid.data_in_04, vid.data_in_03, vid.data_in_02, vid.data_in_01} = '0;
    #2 rst_b = 1'b0;
    #1;
    chk("rst_de_out", vid.de_out, 0);
    chk("rst_row_out", vid.row_out, 0);
    chk("rst_sob_out", vid.sob_out, 0);
    chk("rst_sof_out", vid.sof_out, 0);
    chk("rst_err_len", vid.err_len, 0);
    chk("rst_err_ovf", vid.err_ovf, 0);
    chk("rst_data", {vid.data_out_08, vid.data_out_07, vid.data_out_06, vid.data_out_05,
                     vid.data_out_04, vid.data_out_03, vid.data_out_02, vid.data_out_01}, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    tick();

    // First band with long blanking, then a second band straight after.
    vsync("vs0");
    send_band(H, 10);
    check_flags("bandA");
    send_band(H, 1);
    check_flags("bandB");

    // Short and long lines.
    for (int l = 0; l < 8; l++) begin
      send_line((l == 2) ? 3 : (l == 5) ? 6 : H, 3, 1'b0);
      if (l == 2) check_flags("short_line");
    end
    check_flags("bandC");
    vsync("vs1");

    // vs edge coinciding with the first word of a line.
    send_line(H, 2, 1'b1);
    for (int l = 1; l < 8; l++) send_line(H, 2, 1'b0);
    check_flags("bandD");

    // Second band finishes while the first is still being read out.
    send_band(H, 1);
    send_band(1, 1);
    check_flags("overflow");
    drain("ovf");
    vsync("vs2");

    // Reset in the middle of a readout.
    send_band(H, 2);
    repeat (10) tick();
    rst_b = 1'b0;
    sb.delete();
    wbank_m = 0; line_m = 0; busy_until = -1;
    sof_arm_m = 0; exp_len = 0; exp_ovf = 0;
    #1;
    chk("midrst_de_out", vid.de_out, 0);
    chk("midrst_sof_out", vid.sof_out, 0);
    check_flags("midrst");
    @(posedge clk);
    #1 rst_b = 1'b1;
    tick();

    send_band(H, 3);
    check_flags("bandH");
    drain("final");
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
